// File: rtl/hsi_pkg.sv
// rtl/hsi_pkg.sv - shared types and constants for the HSI master lane selector
package hsi_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PEND  = 2'd1,
    GUARD = 2'd2
  } lane_sel_state_t;

  localparam int ERR_CNT_W   = 4;
  localparam int GUARD_CNT_W = 8;

  // Index width that stays at least one bit wide for a single-lane build.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hsi_m_next_lane.sv
// rtl/hsi_m_next_lane.sv - rotating-priority search for the next healthy lane
// Ports:
//   lane_fail_i  per-lane sticky failure flags
//   act_lane_i   currently active lane (search starts just after it)
//   target_o     first healthy lane after act_lane_i, wrapping
//   found_o      a healthy lane other than act_lane_i exists
module hsi_m_next_lane
  import hsi_pkg::*;
#(
  parameter int N_CH = 2,
  parameter int CW   = clog2_min1(N_CH)
) (
  input  logic [N_CH-1:0] lane_fail_i,
  input  logic [CW-1:0]   act_lane_i,
  output logic [CW-1:0]   target_o,
  output logic            found_o
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest healthy lane is
  // the last one written and therefore wins.
  always_comb begin
    target_o = act_lane_i;
    found_o  = 1'b0;
    idx      = 0;
    for (int k = N_CH - 1; k >= 1; k--) begin
      idx = (int'(act_lane_i) + k) % N_CH;
      if (!lane_fail_i[idx]) begin
        target_o = CW'(idx);
        found_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hsi_m_lane_sel.sv
// rtl/hsi_m_lane_sel.sv - N-lane redundant line manager with deferred failover
// Ports:
//   clk, n_rst         clock, asynchronous active-low reset
//   auto_en, man_sel   automatic failover enable / manual lane index
//   fail_clr           clears failure flags and the error counter
//   tx_busy, rx_busy   controllers mid-frame; a pending switch waits for both idle
//   rx_frame_end, rx_err, rx_timeout   frame outcome events
//   com_in -> com      command bit routed to the active lane only
//   dat -> dat_out     active lane's data returned to the rx controller
//   act_lane, lane_fail, all_fail, switch_pulse   status
module hsi_m_lane_sel
  import hsi_pkg::*;
#(
  parameter  int N_CH      = 2,
  parameter  int ERR_LIM   = 3,
  parameter  int GUARD_CYC = 16,
  localparam int CW        = clog2_min1(N_CH)
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            auto_en,
  input  logic [CW-1:0]   man_sel,
  input  logic            fail_clr,
  input  logic            tx_busy,
  input  logic            rx_busy,
  input  logic            rx_frame_end,
  input  logic            rx_err,
  input  logic            rx_timeout,
  input  logic            com_in,
  output logic [N_CH-1:0] com,
  input  logic [N_CH-1:0] dat,
  output logic            dat_out,
  output logic [CW-1:0]   act_lane,
  output logic [N_CH-1:0] lane_fail,
  output logic            all_fail,
  output logic            switch_pulse
);

  lane_sel_state_t        state_q, state_d;
  logic [CW-1:0]          act_q, act_d;
  logic [CW-1:0]          tgt_q, tgt_d;
  logic [N_CH-1:0]        lane_fail_q, lane_fail_d;
  logic                   all_fail_q, all_fail_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [GUARD_CNT_W-1:0] guard_q, guard_d;
  logic                   sw_q, sw_d;
  logic [N_CH-1:0]        com_q, com_d;
  logic                   dat_q, dat_d;

  logic [CW-1:0] nl_target;
  logic          nl_found;
  logic          fail_ev, succ_ev, in_guard, man_ok;

  hsi_m_next_lane #(.N_CH(N_CH), .CW(CW)) u_next_lane (
    .lane_fail_i (lane_fail_q),
    .act_lane_i  (act_q),
    .target_o    (nl_target),
    .found_o     (nl_found)
  );

  // A frame end and a timeout in the same cycle are one failure.
  assign fail_ev  = (rx_frame_end & rx_err) | rx_timeout;
  assign succ_ev  = rx_frame_end & ~rx_err & ~rx_timeout;
  assign in_guard = (state_q == GUARD);
  assign man_ok   = (int'(man_sel) < N_CH);

  always_comb begin
    state_d     = state_q;
    act_d       = act_q;
    tgt_d       = tgt_q;
    lane_fail_d = lane_fail_q;
    err_cnt_d   = err_cnt_q;
    guard_d     = guard_q;
    sw_d        = 1'b0;

    // Error accounting on the active lane; outcomes inside the guard
    // window belong to no lane and are dropped.
    if (!in_guard) begin
      if (fail_ev) begin
        if (err_cnt_q < ERR_CNT_W'(ERR_LIM)) begin
          err_cnt_d = err_cnt_q + 1'b1;
        end
        if (err_cnt_d == ERR_CNT_W'(ERR_LIM)) begin
          lane_fail_d[act_q] = 1'b1;
        end
      end else if (succ_ev) begin
        err_cnt_d = '0;
      end
    end

    case (state_q)
      RUN: begin
        if (auto_en) begin
          if (lane_fail_q[act_q] && nl_found) begin
            tgt_d   = nl_target;
            state_d = PEND;
          end
        end else if (man_ok && (man_sel != act_q)) begin
          tgt_d   = man_sel;
          state_d = PEND;
        end
      end
      PEND: begin
        // In manual mode the operator's choice overrides any latched target;
        // selecting the current lane cancels the switch.
        if (!auto_en && man_ok) begin
          tgt_d = man_sel;
        end
        if (!auto_en && man_ok && (man_sel == act_q)) begin
          state_d = RUN;
        end else if (!tx_busy && !rx_busy) begin
          act_d     = tgt_d;
          sw_d      = 1'b1;
          err_cnt_d = '0;
          guard_d   = GUARD_CNT_W'(GUARD_CYC);
          state_d   = GUARD;
        end
      end
      GUARD: begin
        guard_d = guard_q - 1'b1;
        if (guard_q <= GUARD_CNT_W'(1)) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    if (fail_clr) begin
      lane_fail_d = '0;
      err_cnt_d   = '0;
    end

    all_fail_d = &lane_fail_d;
  end

  always_comb begin
    com_d = '0;
    dat_d = 1'b0;
    if (!in_guard) begin
      com_d[act_q] = com_in;
      dat_d        = dat[act_q];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= RUN;
      act_q       <= '0;
      tgt_q       <= '0;
      lane_fail_q <= '0;
      all_fail_q  <= 1'b0;
      err_cnt_q   <= '0;
      guard_q     <= '0;
      sw_q        <= 1'b0;
      com_q       <= '0;
      dat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      act_q       <= act_d;
      tgt_q       <= tgt_d;
      lane_fail_q <= lane_fail_d;
      all_fail_q  <= all_fail_d;
      err_cnt_q   <= err_cnt_d;
      guard_q     <= guard_d;
      sw_q        <= sw_d;
      com_q       <= com_d;
      dat_q       <= dat_d;
    end
  end

  assign com          = com_q;
  assign dat_out      = dat_q;
  assign act_lane     = act_q;
  assign lane_fail    = lane_fail_q;
  assign all_fail     = all_fail_q;
  assign switch_pulse = sw_q;

endmodule

// File: tb/tb_hsi_m_lane_sel.sv
// tb/tb_hsi_m_lane_sel.sv - self-checking bench for hsi_m_lane_sel
module tb_hsi_m_lane_sel;

  localparam int NCH  = 5;
  localparam int LIM  = 3;
  localparam int GCYC = 16;

  logic           clk, n_rst;
  logic           auto_en, fail_clr, tx_busy, rx_busy;
  logic           rx_frame_end, rx_err, rx_timeout, com_in;
  logic [2:0]     man_sel, act_lane;
  logic [NCH-1:0] com, dat, lane_fail;
  logic           dat_out, all_fail, switch_pulse;

  hsi_m_lane_sel #(.N_CH(NCH), .ERR_LIM(LIM), .GUARD_CYC(GCYC)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .auto_en      (auto_en),
    .man_sel      (man_sel),
    .fail_clr     (fail_clr),
    .tx_busy      (tx_busy),
    .rx_busy      (rx_busy),
    .rx_frame_end (rx_frame_end),
    .rx_err       (rx_err),
    .rx_timeout   (rx_timeout),
    .com_in       (com_in),
    .com          (com),
    .dat          (dat),
    .dat_out      (dat_out),
    .act_lane     (act_lane),
    .lane_fail    (lane_fail),
    .all_fail     (all_fail),
    .switch_pulse (switch_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int swc    = 0;

  // Reference: which lane is live, whether a switch is wanted (and to
  // where), and how many guard cycles remain.
  int           m_act, m_cnt, m_guard_left, m_target;
  bit           m_pending;
  bit [NCH-1:0] m_fail, m_com;
  bit           m_all, m_sw, m_dat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_act = 0; m_cnt = 0; m_guard_left = 0; m_target = 0; m_pending = 0;
    m_fail = '0; m_com = '0; m_all = 0; m_sw = 0; m_dat = 0;
  endtask

  task automatic model_edge();
    bit [NCH-1:0] old_fail;
    bit guarding, fe, su, found;
    int tgt;
    old_fail = m_fail;
    guarding = (m_guard_left > 0);
    fe = (rx_frame_end && rx_err) || rx_timeout;
    su = rx_frame_end && !rx_err && !rx_timeout;

    m_com = '0;
    if (!guarding) m_com[m_act] = com_in;
    m_dat = guarding ? 1'b0 : dat[m_act];
    m_sw  = 0;

    if (!guarding) begin
      if (fe) begin
        if (m_cnt < LIM) m_cnt++;
        if (m_cnt == LIM) m_fail[m_act] = 1'b1;
      end else if (su) begin
        m_cnt = 0;
      end
    end

    if (guarding) begin
      m_guard_left--;
    end else if (!m_pending) begin
      found = 0; tgt = m_act;
      for (int k = NCH - 1; k >= 1; k--)
        if (!old_fail[(m_act + k) % NCH]) begin found = 1; tgt = (m_act + k) % NCH; end
      if (auto_en) begin
        if (old_fail[m_act] && found) begin m_pending = 1; m_target = tgt; end
      end else if (man_sel < NCH && man_sel != m_act) begin
        m_pending = 1; m_target = man_sel;
      end
    end else begin
      if (!auto_en && man_sel < NCH) m_target = man_sel;
      if (!auto_en && man_sel < NCH && man_sel == m_act) begin
        m_pending = 0;
      end else if (!tx_busy && !rx_busy) begin
        m_act = m_target; m_sw = 1; m_cnt = 0; m_guard_left = GCYC; m_pending = 0;
      end
    end

    if (fail_clr) begin m_fail = '0; m_cnt = 0; end
    m_all = &m_fail;
  endtask

  task automatic step();
    com_in = 1'($urandom);
    dat    = NCH'($urandom);
    @(posedge clk);
    model_edge();
    #1;
    if (switch_pulse) swc++;
    chk("act_lane", act_lane, m_act);
    chk("lane_fail", lane_fail, m_fail);
    chk("all_fail", all_fail, m_all);
    chk("switch_pulse", switch_pulse, m_sw);
    chk("com", com, m_com);
    chk("dat_out", dat_out, m_dat);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic frame(input bit err);
    rx_frame_end = 1; rx_err = err; step();
    rx_frame_end = 0; rx_err = 0;   step();
  endtask

  task automatic go_manual(input int lane);
    auto_en = 0; man_sel = 3'(lane); idle(GCYC + 6);
  endtask

  initial begin
    n_rst = 0; auto_en = 1; man_sel = 0; fail_clr = 0; tx_busy = 0; rx_busy = 0;
    rx_frame_end = 0; rx_err = 0; rx_timeout = 0; com_in = 1; dat = '1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_act", act_lane, 0);
    chk("rst_fail", lane_fail, 0);
    chk("rst_all", all_fail, 0);
    chk("rst_sw", switch_pulse, 0);
    chk("rst_com", com, 0);
    chk("rst_dat", dat_out, 0);
    n_rst = 1;

    // Auto failover off lane 0 with idle controllers.
    swc = 0;
    repeat (LIM) frame(1);
    idle(GCYC + 6);
    chk("s1_act", act_lane, 1);
    chk("s1_fail", lane_fail, 5'b00001);
    chk("s1_swcnt", swc, 1);

    // Threshold on lane 1 while tx is busy: switch waits for tx_busy to drop.
    tx_busy = 1; swc = 0;
    repeat (LIM) frame(1);
    idle(40);
    chk("s2_hold_act", act_lane, 1);
    chk("s2_hold_sw", swc, 0);
    tx_busy = 0;
    step();
    chk("s2_act", act_lane, 2);
    chk("s2_sw", switch_pulse, 1);
    idle(GCYC + 4);

    // Fail every other lane manually, then lane 0 in auto mode -> all_fail.
    for (int l = 2; l < NCH; l++) begin
      go_manual(l);
      repeat (LIM) frame(1);
      chk("man_flag", lane_fail[l], 1);
      chk("man_act", act_lane, l);
    end
    go_manual(0);
    auto_en = 1; swc = 0;
    repeat (LIM) frame(1);
    idle(6);
    chk("s3_all", all_fail, 1);
    chk("s3_act", act_lane, 0);
    chk("s3_swcnt", swc, 0);
    fail_clr = 1; step(); fail_clr = 0;
    chk("s3_clr_fail", lane_fail, 0);
    chk("s3_clr_all", all_fail, 0);

    // Out-of-range manual selection is ignored.
    auto_en = 0; man_sel = 3'd6; swc = 0;
    idle(10);
    chk("s5_badsel", act_lane, 0);
    chk("s5_badsw", swc, 0);

    // A good frame clears the count; a combined event counts once.
    man_sel = 0;
    frame(1); frame(1); frame(0); frame(1); frame(1);
    chk("s4_noflag", lane_fail, 0);
    frame(0);
    rx_frame_end = 1; rx_err = 1; rx_timeout = 1; step();
    rx_frame_end = 0; rx_err = 0; rx_timeout = 0; step();
    frame(1);
    chk("s4_dual_once", lane_fail[0], 0);
    frame(1);
    chk("s4_flag", lane_fail[0], 1);

    // Reset in the middle of a guard interval on lane 3.
    man_sel = 3;
    for (int i = 0; i < 60 && !switch_pulse; i++) step();
    chk("s6_sw_seen", switch_pulse, 1);
    idle(4);
    #2 n_rst = 0;
    #1;
    chk("s6_act", act_lane, 0);
    chk("s6_com", com, 0);
    chk("s6_dat", dat_out, 0);
    chk("s6_sw", switch_pulse, 0);
    model_reset();
    @(posedge clk); #1;
    auto_en = 1; man_sel = 0; n_rst = 1;

    // Randomized traffic against the reference.
    for (int i = 0; i < 3000; i++) begin
      rx_frame_end = ($urandom_range(0, 5) == 0);
      rx_err       = 1'($urandom);
      rx_timeout   = ($urandom_range(0, 24) == 0);
      fail_clr     = ($urandom_range(0, 249) == 0);
      tx_busy      = ($urandom_range(0, 2) == 0);
      rx_busy      = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 199) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 59) == 0) man_sel = 3'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
